// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the iterative multiply/divide sequencer
package muldiv_pkg;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add multiply / restoring divide iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] low,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] low_next,
    output logic             q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = low[0] ? ({1'b0, acc} + {1'b0, opnd}) : {1'b0, acc};
        rem_sh = {acc, low[WIDTH-1]};
        // rem < divisor holds every step, so bit WIDTH of the difference is the borrow
        diff   = rem_sh - {1'b0, opnd};
        q_bit  = 1'b0;
        if (is_div) begin
            q_bit    = ~diff[WIDTH];
            acc_next = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            low_next = {low[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = sum[WIDTH:1];
            low_next = {sum[0], low[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - HI/LO owner running 32-iteration mult/div with sign fixup
import muldiv_pkg::*;

module muldiv_seq #(
    parameter int WIDTH = MD_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_e          state, state_next;
    logic               accept, calc_en, fix_en;
    logic [CNT_W-1:0]   count;
    md_op_e             op_r;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   acc, low, opnd;
    logic [WIDTH-1:0]   acc_step, low_step;
    logic               q_bit;
    logic               is_div, is_signed, op_signed_in;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

    assign is_div       = op_r[1];
    assign is_signed    = ~op_r[0];
    assign op_signed_in = ~op[0];
    assign mag_a        = (op_signed_in && a[WIDTH-1]) ? -a : a;
    assign mag_b        = (op_signed_in && b[WIDTH-1]) ? -b : b;
    assign busy         = (state != IDLE);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .low      (low),
        .opnd     (opnd),
        .acc_next (acc_step),
        .low_next (low_step),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        calc_en    = 1'b0;
        fix_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                calc_en = 1'b1;
                if (count == CNT_W'(WIDTH - 1)) state_next = FIX;
            end
            FIX: begin
                fix_en     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Results are built from magnitudes; signs are reapplied here in FIX only
    always_comb begin
        prod     = {acc, low};
        prod_fix = (is_signed && (sign_a ^ sign_b)) ? -prod : prod;
        quo_fix  = (is_signed && (sign_a ^ sign_b)) ? -low : low;
        rem_fix  = (is_signed && sign_a) ? -acc : acc;
        if (is_signed && (opnd == '0)) quo_fix = '1;
        res_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = is_div ? quo_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            op_r   <= MD_MULT;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            acc    <= '0;
            low    <= '0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= fix_en;
            if (accept) begin
                op_r   <= md_op_e'(op);
                sign_a <= a[WIDTH-1];
                sign_b <= b[WIDTH-1];
                acc    <= '0;
                count  <= '0;
                low    <= op[1] ? mag_a : mag_b;
                opnd   <= op[1] ? mag_b : mag_a;
            end
            if (calc_en) begin
                acc   <= acc_step;
                low   <= is_div ? {low_step[WIDTH-1:1], q_bit} : low_step;
                count <= count + 1'b1;
            end
            if (fix_en) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (state == IDLE && !start) begin
                if (mthi) hi <= a;
                if (mtlo) lo <= a;
            end
        end
    end

endmodule
